// File: rtl/accel_cmd_issuer_if.sv
// Core-side command/result handshake bundle for the crypto accelerator
// command issuer. Signal suffixes are from the issuer's point of view.
interface accel_cmd_issuer_if #(
  parameter int unsigned DATA_W = 128
);
  // Command channel from the custom-instruction decode stage.
  logic              cmd_valid_i;
  logic [1:0]        cmd_op_i;
  logic [DATA_W-1:0] cmd_data_i;
  logic              cmd_ready_o;

  // Result channel to writeback.
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  logic              res_err_o;

  // Core side: issues commands, consumes results.
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_data_i, res_ready_i,
    input  cmd_ready_o, res_valid_o, res_data_o, res_err_o
  );

  // Issuer side.
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_data_i, res_ready_i,
    output cmd_ready_o, res_valid_o, res_data_o, res_err_o
  );
endinterface

// File: rtl/accel_cmd_issuer.sv
// Command issuer between the core's custom-instruction stage and the 128-bit
// crypto accelerator: sequences key-load / encrypt / decrypt strobes, holds the
// operand on the accelerator input, captures the result and returns it through
// a valid/ready handshake. A saturating timeout turns a hung accelerator into
// an error response.
module accel_cmd_issuer #(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  accel_cmd_issuer_if.slave    cmd_if,
  output logic                 busy_o,
  output logic                 acc_load_key_o,
  output logic                 acc_start_enc_o,
  output logic                 acc_start_dec_o,
  output logic [DATA_W-1:0]    acc_data_o,
  input  logic                 acc_ready_i,
  input  logic                 acc_done_i,
  input  logic                 acc_rf_en_i,
  input  logic [DATA_W-1:0]    acc_data_i
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // BUSY is left on the edge at which the counter would reach TIMEOUT_CYCLES,
  // so exactly TIMEOUT_CYCLES cycles are spent in BUSY.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_BUSY,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD_KEY = 2'b00,
    OP_ENCRYPT  = 2'b01,
    OP_DECRYPT  = 2'b10,
    OP_ILLEGAL  = 2'b11
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmd_ready;
  logic              res_valid;
  logic              timeout_hit;

  assign timeout_hit = (cnt_q >= CNT_LAST);

  // Next-state, register-update and Moore output decode for the command FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d         = state_q;
    op_d            = op_q;
    opnd_d          = opnd_q;
    res_d           = res_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    cmd_ready       = 1'b0;
    res_valid       = 1'b0;
    busy_o          = 1'b1;
    acc_load_key_o  = 1'b0;
    acc_start_enc_o = 1'b0;
    acc_start_dec_o = 1'b0;
    acc_data_o      = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy_o    = 1'b0;
        if (cmd_if.cmd_valid_i) begin
          op_d    = op_e'(cmd_if.cmd_op_i);
          opnd_d  = cmd_if.cmd_data_i;
          state_d = acc_ready_i ? S_ISSUE : S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (acc_ready_i) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        acc_data_o = opnd_q;
        case (op_q)
          OP_LOAD_KEY: begin
            acc_load_key_o = 1'b1;
            state_d        = S_IDLE;
          end
          OP_ENCRYPT: begin
            acc_start_enc_o = 1'b1;
            state_d         = S_BUSY;
            cnt_d           = '0;
            res_d           = '0;
            err_d           = 1'b0;
          end
          OP_DECRYPT: begin
            acc_start_dec_o = 1'b1;
            state_d         = S_BUSY;
            cnt_d           = '0;
            res_d           = '0;
            err_d           = 1'b0;
          end
          default: begin
            // Illegal opcode: no strobe, straight to an error response.
            state_d = S_RESP;
            res_d   = '0;
            err_d   = 1'b1;
          end
        endcase
      end

      S_BUSY: begin
        acc_data_o = opnd_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (acc_rf_en_i) res_d = acc_data_i;
        // Completion takes priority over a timeout landing in the same cycle.
        if (acc_done_i) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end

      S_RESP: begin
        res_valid = 1'b1;
        if (cmd_if.res_ready_i) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD_KEY;
      opnd_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_if.cmd_ready_o = cmd_ready;
  assign cmd_if.res_valid_o = res_valid;
  assign cmd_if.res_data_o  = res_q;
  assign cmd_if.res_err_o   = err_q;

endmodule

// File: tb/tb_accel_cmd_issuer.sv
// Self-checking bench for accel_cmd_issuer: a directed vector table, hand
// sequences for timeout and reset corner cases, and randomized transactions
// checked against a latency/result model derived from the command rules.
module tb_accel_cmd_issuer;

  localparam int DW = 128;
  typedef logic [DW-1:0] word_t;

  typedef struct {
    string      name;
    logic [1:0] op;
    word_t      data;
    int         rdy_delay;   // cycles acc_ready_i stays low from the accept cycle
    int         busy_n;      // accelerator busy cycles before its done pulse
    int         hold;        // cycles res_ready_i stays low after res_valid_o
    logic [2:0] exp_strobe;  // {load_key, start_enc, start_dec}
    int         exp_issue;   // cycle of the strobe, accept = cycle 0
    int         exp_resp;    // cycle res_valid_o rises, -1 when no result
    logic       exp_err;
    word_t      exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: default timeout.
  accel_cmd_issuer_if #(.DATA_W(DW)) ifa ();
  logic  a_busy, a_ld, a_enc, a_dec;
  word_t a_acc_data_o;
  logic  a_acc_ready, a_done, a_rf_en;
  word_t a_acc_data_i;

  accel_cmd_issuer #(.DATA_W(DW)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_if(ifa), .busy_o(a_busy),
    .acc_load_key_o(a_ld), .acc_start_enc_o(a_enc), .acc_start_dec_o(a_dec),
    .acc_data_o(a_acc_data_o), .acc_ready_i(a_acc_ready), .acc_done_i(a_done),
    .acc_rf_en_i(a_rf_en), .acc_data_i(a_acc_data_i)
  );

  // DUT B: short timeout.
  accel_cmd_issuer_if #(.DATA_W(DW)) ifb ();
  logic  b_busy, b_ld, b_enc, b_dec;
  word_t b_acc_data_o;
  logic  b_acc_ready, b_done, b_rf_en;
  word_t b_acc_data_i;

  accel_cmd_issuer #(.DATA_W(DW), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_if(ifb), .busy_o(b_busy),
    .acc_load_key_o(b_ld), .acc_start_enc_o(b_enc), .acc_start_dec_o(b_dec),
    .acc_data_o(b_acc_data_o), .acc_ready_i(b_acc_ready), .acc_done_i(b_done),
    .acc_rf_en_i(b_rf_en), .acc_data_i(b_acc_data_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected behaviour from the command rules: issue one cycle after ready is
  // seen, accelerator done N+1 cycles after the strobe, result one cycle later.
  function automatic vec_t ref_model(input string name, input logic [1:0] op, input word_t data,
                                     input int d, input int n, input int hold);
    vec_t v;
    v.name = name; v.op = op; v.data = data;
    v.rdy_delay = d; v.busy_n = n; v.hold = hold;
    v.exp_issue = d + 1;
    case (op)
      2'b00:   begin v.exp_strobe = 3'b100; v.exp_resp = -1;        v.exp_err = 1'b0; v.exp_data = '0;        end
      2'b01:   begin v.exp_strobe = 3'b010; v.exp_resp = d + n + 3; v.exp_err = 1'b0; v.exp_data = data << 1; end
      2'b10:   begin v.exp_strobe = 3'b001; v.exp_resp = d + n + 3; v.exp_err = 1'b0; v.exp_data = data >> 1; end
      default: begin v.exp_strobe = 3'b000; v.exp_resp = d + 2;     v.exp_err = 1'b1; v.exp_data = '0;        end
    endcase
    return v;
  endfunction

  // One transaction on DUT A. The accelerator model reacts to the strobe it
  // sees: shift-left for encrypt, shift-right for decrypt, result on the last
  // busy cycle or on the done cycle, junk rf_en beats before it. With noise,
  // done/rf_en toggle randomly whenever the accelerator is not working.
  task automatic run_txn(input vec_t v, input bit noise);
    int    s_cycle, s_cnt, rv_cycle, ready_cycle, acc_start, res_wr;
    logic [2:0] s_vec;
    word_t s_data, r_data, r_accd, acc_res;
    logic  r_err, busy1, crdy1, crdy0;
    bit    stable, fin;
    s_cycle = -1; s_cnt = 0; rv_cycle = -1; ready_cycle = -1; acc_start = -1;
    res_wr = int'($urandom_range(0, 1));
    s_vec = '0; s_data = '0; r_data = '0; r_accd = '0; acc_res = '0;
    r_err = 1'b0; busy1 = 1'b0; crdy1 = 1'b1; crdy0 = 1'b0;
    stable = 1'b1; fin = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      if (k == 0) crdy0 = ifa.cmd_ready_o;
      if (k == 1) begin busy1 = a_busy; crdy1 = ifa.cmd_ready_o; end
      if (a_ld || a_enc || a_dec) begin
        s_cnt++;
        if (s_cycle < 0) begin s_cycle = k; s_vec = {a_ld, a_enc, a_dec}; s_data = a_acc_data_o; end
      end
      if ((a_enc || a_dec) && acc_start < 0) begin
        acc_start = k;
        acc_res   = a_enc ? (a_acc_data_o << 1) : (a_acc_data_o >> 1);
      end
      if (ifa.res_valid_o) begin
        if (rv_cycle < 0) begin
          rv_cycle = k; r_data = ifa.res_data_o; r_err = ifa.res_err_o; r_accd = a_acc_data_o;
        end else if (ifa.res_data_o !== r_data || ifa.res_err_o !== r_err) begin
          stable = 1'b0;
        end
      end
      if (k > 0 && ifa.cmd_ready_o) begin ready_cycle = k; fin = 1'b1; end

      ifa.cmd_valid_i = (k == 0);
      ifa.cmd_op_i    = (k == 0) ? v.op : 2'($urandom);
      ifa.cmd_data_i  = (k == 0) ? v.data : rand_word();
      ifa.res_ready_i = (rv_cycle >= 0) && (k == rv_cycle + v.hold);
      if (acc_start >= 0 && k > acc_start && k <= acc_start + v.busy_n + 1) begin
        a_acc_ready = 1'b0;
        a_done      = (k == acc_start + v.busy_n + 1);
        if (k == acc_start + v.busy_n + res_wr) begin
          a_rf_en = 1'b1; a_acc_data_i = acc_res;
        end else if (k < acc_start + v.busy_n + res_wr) begin
          a_rf_en = 1'($urandom); a_acc_data_i = rand_word();
        end else begin
          a_rf_en = 1'b0; a_acc_data_i = rand_word();
        end
      end else begin
        a_acc_ready  = (k >= v.rdy_delay);
        a_done       = noise & 1'($urandom);
        a_rf_en      = noise & 1'($urandom);
        a_acc_data_i = rand_word();
      end
    end
    if (!fin) check({v.name, ".cycle_budget"}, 0, 1);
    check({v.name, ".ready_at_accept"}, crdy0, 1);
    check({v.name, ".busy_c1"}, busy1, 1);
    check({v.name, ".ready_c1"}, crdy1, 0);
    if (v.exp_strobe != 3'b000) begin
      check({v.name, ".strobe_sel"}, s_vec, v.exp_strobe);
      check({v.name, ".strobe_cycle"}, s_cycle, v.exp_issue);
      check({v.name, ".strobe_count"}, s_cnt, 1);
      check({v.name, ".acc_data"}, s_data, v.data);
    end else begin
      check({v.name, ".no_strobe"}, s_cnt, 0);
    end
    if (v.exp_resp >= 0) begin
      check({v.name, ".resp_cycle"}, rv_cycle, v.exp_resp);
      check({v.name, ".res_data"}, r_data, v.exp_data);
      check({v.name, ".res_err"}, r_err, v.exp_err);
      check({v.name, ".res_stable"}, stable, 1);
      check({v.name, ".acc_data_in_resp"}, r_accd, 0);
      check({v.name, ".ready_back"}, ready_cycle, v.exp_resp + v.hold + 1);
    end else begin
      check({v.name, ".no_resp"}, rv_cycle, -1);
      check({v.name, ".ready_back"}, ready_cycle, v.exp_issue + 1);
    end
  endtask

  // Encrypt on DUT B (8-cycle timeout). rf_en carries junk on every BUSY cycle;
  // a done pulse at done_k carries the word that must be returned.
  task automatic run_b(input string name, input int done_k, input int exp_rv, input logic exp_err);
    int    s_cycle, rv_cycle;
    word_t good, r_data, exp_data;
    logic  r_err;
    bit    fin, bad_strobe;
    s_cycle = -1; rv_cycle = -1; r_data = '0; r_err = 1'b0; fin = 1'b0; bad_strobe = 1'b0;
    good = rand_word();
    exp_data = exp_err ? '0 : good;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk);
      if (b_enc && s_cycle < 0) s_cycle = k;
      if (b_ld || b_dec) bad_strobe = 1'b1;
      if (ifb.res_valid_o && rv_cycle < 0) begin rv_cycle = k; r_data = ifb.res_data_o; r_err = ifb.res_err_o; end
      if (k > 0 && ifb.cmd_ready_o) fin = 1'b1;
      ifb.cmd_valid_i = (k == 0);
      ifb.cmd_op_i    = 2'b01;
      ifb.cmd_data_i  = rand_word();
      ifb.res_ready_i = (rv_cycle >= 0) && (k == rv_cycle);
      b_acc_ready     = 1'b1;
      b_done          = (k == done_k);
      b_rf_en         = (k >= 2);
      b_acc_data_i    = (k == done_k) ? good : rand_word();
    end
    if (!fin) check({name, ".cycle_budget"}, 0, 1);
    check({name, ".enc_cycle"}, s_cycle, 1);
    check({name, ".other_strobes"}, bad_strobe, 0);
    check({name, ".resp_cycle"}, rv_cycle, exp_rv);
    check({name, ".res_err"}, r_err, exp_err);
    check({name, ".res_data"}, r_data, exp_data);
  endtask

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"key_load", 2'b00, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 0, 0,
                3'b100, 1, -1, 1'b0, 128'h0};
    vecs[1] = '{"encrypt_64", 2'b01, 128'h1, 0, 64, 5,
                3'b010, 1, 67, 1'b0, 128'h2};
    vecs[2] = '{"decrypt_wait", 2'b10, 128'h80000000_00000000_00000000_000000F0, 10, 16, 1,
                3'b001, 11, 29, 1'b0, 128'h40000000_00000000_00000000_00000078};
    vecs[3] = '{"illegal", 2'b11, 128'hDEAD, 0, 0, 0,
                3'b000, 1, 2, 1'b1, 128'h0};
    vecs[4] = '{"illegal_wait", 2'b11, 128'hBEEF, 3, 0, 2,
                3'b000, 4, 5, 1'b1, 128'h0};
    vecs[5] = '{"encrypt_short", 2'b01, 128'h1234, 2, 1, 0,
                3'b010, 3, 6, 1'b0, 128'h2468};
    vecs[6] = '{"key_load_wait", 2'b00, 128'hCAFE, 4, 0, 0,
                3'b100, 5, -1, 1'b0, 128'h0};

    rst = 1'b1;
    ifa.cmd_valid_i = 1'b0; ifa.cmd_op_i = 2'b00; ifa.cmd_data_i = '0; ifa.res_ready_i = 1'b0;
    ifb.cmd_valid_i = 1'b0; ifb.cmd_op_i = 2'b00; ifb.cmd_data_i = '0; ifb.res_ready_i = 1'b0;
    a_acc_ready = 1'b1; a_done = 1'b0; a_rf_en = 1'b0; a_acc_data_i = '0;
    b_acc_ready = 1'b1; b_done = 1'b0; b_rf_en = 1'b0; b_acc_data_i = '0;

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    check("reset.cmd_ready", ifa.cmd_ready_o, 1);
    check("reset.busy", a_busy, 0);
    check("reset.res_valid", ifa.res_valid_o, 0);
    check("reset.res_err", ifa.res_err_o, 0);
    check("reset.res_data", ifa.res_data_o, 0);
    check("reset.strobes", {a_ld, a_enc, a_dec}, 0);
    check("reset.acc_data", a_acc_data_o, 0);
    check("reset_b.cmd_ready", ifb.cmd_ready_o, 1);
    check("reset_b.busy_valid", {b_busy, ifb.res_valid_o, b_ld, b_enc, b_dec}, 0);
    check("reset_b.acc_data", b_acc_data_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b1);

    // Timeout and done/timeout collision on the short-timeout instance.
    run_b("timeout", -1, 10, 1'b1);
    run_b("done_at_timeout", 9, 10, 1'b0);
    run_b("done_early", 5, 6, 1'b0);

    // Reset during cycle 20 of an encrypt; a late done must not revive it.
    begin
      bit   seen_valid;
      logic busy20;
      seen_valid = 1'b0; busy20 = 1'b0;
      for (int k = 0; k < 90; k++) begin
        @(negedge clk);
        if (k == 20) busy20 = a_busy;
        if (k == 21) begin
          check("rst_mid.busy", a_busy, 0);
          check("rst_mid.cmd_ready", ifa.cmd_ready_o, 1);
          check("rst_mid.res_data", ifa.res_data_o, 0);
          check("rst_mid.acc_data", a_acc_data_o, 0);
        end
        if (k >= 21 && ifa.res_valid_o) seen_valid = 1'b1;
        rst             = (k == 20);
        ifa.cmd_valid_i = (k == 0);
        ifa.cmd_op_i    = 2'b01;
        ifa.cmd_data_i  = rand_word();
        ifa.res_ready_i = 1'b0;
        a_acc_ready     = 1'b1;
        a_done          = (k == 66);
        a_rf_en         = (k == 66);
        a_acc_data_i    = rand_word();
      end
      check("rst_mid.busy_before", busy20, 1);
      check("rst_mid.no_resp", seen_valid, 0);
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 30; i++) begin
      vec_t rv;
      rv = ref_model($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), rand_word(),
                     int'($urandom_range(0, 5)), int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 3)));
      run_txn(rv, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
